// File: rtl/instr_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Holds the word type, the buffered {pc, instr} entry and PC arithmetic.
package instr_fetch_pkg;

   localparam int WORD_WIDTH  = 32;
   localparam int INSTR_BYTES = 4;

   typedef logic [WORD_WIDTH-1:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t instr;
   } fetch_entry_t;

   localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

   // Fetch addresses are always word aligned; low bits of a target are dropped.
   function automatic word_t align_word(input word_t addr);
      return {addr[WORD_WIDTH-1:2], 2'b00};
   endfunction

   // Natural 32-bit wrap takes 32'hFFFF_FFFC back to zero.
   function automatic word_t next_pc(input word_t pc);
      return pc + word_t'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the fetch stage's memory port, redirect input and decode output.
// The master view belongs to the fetch stage; the slave view to its environment.
interface instr_fetch_if;
   import instr_fetch_pkg::*;

   logic  imem_req_valid;
   logic  imem_req_ready;
   word_t imem_addr;
   logic  imem_rsp_valid;
   word_t imem_rsp_data;
   logic  redirect;
   word_t redirect_pc;
   logic  instr_valid;
   logic  instr_ready;
   word_t instr;
   word_t pc;

   modport master (
      output imem_req_valid,
      output imem_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      input  redirect,
      input  redirect_pc,
      output instr_valid,
      output instr,
      output pc,
      input  instr_ready
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data,
      output redirect,
      output redirect_pc,
      input  instr_valid,
      input  instr,
      input  pc,
      output instr_ready
   );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small first-word-fall-through FIFO holding fetched {pc, instr} entries.
// Flush empties it in one cycle; storage itself carries no reset.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees the slot a push on a full FIFO would need.
   assign push_ok = push & (~full | pop_ok);
   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= bump(wr_ptr_reg);
         end
         if (pop_ok) begin
            rd_ptr_reg <= bump(rd_ptr_reg);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push_ok && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
               mem[gi] <= wr_data;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word-aligned requests under a credit limit,
// buffers in-order responses with their PC and drops stale ones after a redirect.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter word_t RESET_PC   = 32'h0000_0000,
   parameter int    FIFO_DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   instr_fetch_if.master bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   word_t            pc_reg;
   word_t            rsp_pc_reg;
   logic [CNT_W-1:0] out_cnt_reg;
   logic [CNT_W-1:0] drop_cnt_reg;
   logic             req_pend_reg;

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;

   logic [CNT_W:0]   in_use;
   logic             credit_ok;
   logic             req_valid;
   logic             req_fire;
   logic             rsp_stale;
   logic             rsp_keep;
   logic             push;
   logic             pop;

   assign pop = ~fifo_empty & bus.instr_ready;

   // Slots already promised: outstanding requests plus buffered entries,
   // less the head leaving this cycle so a streaming pipe sustains one per cycle.
   always_comb begin
      in_use    = {1'b0, out_cnt_reg} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop};
      credit_ok = (in_use < (CNT_W + 1)'(FIFO_DEPTH));
   end

   // Once raised, a request is held until accepted so address and valid stay stable.
   assign req_valid = rstn_i & ~bus.redirect & (req_pend_reg | credit_ok);
   assign req_fire  = req_valid & bus.imem_req_ready;

   assign rsp_stale = bus.imem_rsp_valid & (drop_cnt_reg != '0);
   assign rsp_keep  = bus.imem_rsp_valid & (drop_cnt_reg == '0) & ~bus.redirect;
   assign push      = rsp_keep & (~fifo_full | pop);

   assign push_entry = '{pc: rsp_pc_reg, instr: bus.imem_rsp_data};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pc_reg       <= RESET_PC;
         rsp_pc_reg   <= RESET_PC;
         out_cnt_reg  <= '0;
         drop_cnt_reg <= '0;
         req_pend_reg <= 1'b0;
      end else if (bus.redirect) begin
         pc_reg       <= align_word(bus.redirect_pc);
         rsp_pc_reg   <= align_word(bus.redirect_pc);
         req_pend_reg <= 1'b0;
         // Everything still in flight is stale; a response landing now is dropped too.
         if (bus.imem_rsp_valid) begin
            out_cnt_reg  <= out_cnt_reg - CNT_W'(1);
            drop_cnt_reg <= out_cnt_reg - CNT_W'(1);
         end else begin
            drop_cnt_reg <= out_cnt_reg;
         end
      end else begin
         req_pend_reg <= req_valid & ~bus.imem_req_ready;
         if (req_fire) begin
            pc_reg <= next_pc(pc_reg);
         end
         if (push) begin
            rsp_pc_reg <= next_pc(rsp_pc_reg);
         end
         if (rsp_stale) begin
            drop_cnt_reg <= drop_cnt_reg - CNT_W'(1);
         end
         case ({req_fire, bus.imem_rsp_valid})
            2'b10:   out_cnt_reg <= out_cnt_reg + CNT_W'(1);
            2'b01:   out_cnt_reg <= out_cnt_reg - CNT_W'(1);
            default: out_cnt_reg <= out_cnt_reg;
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_i),
      .rst_n   (rstn_i),
      .push    (push),
      .pop     (pop),
      .flush   (bus.redirect),
      .wr_data (push_entry),
      .rd_data (head_entry),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_addr      = pc_reg;
   assign bus.instr_valid    = ~fifo_empty;
   // Decode sees zeros rather than stale storage whenever nothing is buffered.
   assign bus.instr          = fifo_empty ? '0 : head_entry.instr;
   assign bus.pc             = fifo_empty ? '0 : head_entry.pc;

endmodule
